csa_accum_sequencer: RTL and testbench

//  Streaming multi-operand accumulator for the GEMV dot-product path.

---
 rtl/csa_pkg.sv | 19 +
 rtl/csa_accum_sequencer_if.sv | 31 +++
 rtl/csa_3to2_row.sv | 22 ++
 rtl/csa_accum_sequencer.sv | 98 +++++++++
 tb/tb_csa_accum_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared types and default widths for the carry-save accumulator.
//   DEF_IN_W      operand width (unsigned, zero-extended into the accumulator)
//   DEF_ACC_W     accumulator / result width; all arithmetic wraps mod 2^DEF_ACC_W
//   DEF_MAX_TERMS longest frame that cannot overflow the accumulator
//   DEF_CNT_W     term-counter width; one extra bit so MAX_TERMS+1 is representable
package csa_pkg;

  localparam int DEF_IN_W      = 21;
  localparam int DEF_ACC_W     = 28;
  localparam int DEF_MAX_TERMS = 2 ** (DEF_ACC_W - DEF_IN_W);
  localparam int DEF_CNT_W     = $clog2(DEF_MAX_TERMS) + 1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/csa_accum_sequencer_if.sv
// csa_accum_sequencer_if: operand stream in, frame result out.
//   in_valid/in_ready/in_data/in_last       operand beats (accept = in_valid & in_ready)
//   out_valid/out_ready/out_data/out_count/out_ovf  frame result, held until accepted
//   busy                                    accumulator holds a partial or pending frame
// Modports: master = producer/consumer side (testbench, upstream/downstream),
//           slave  = the accumulator itself.
interface csa_accum_sequencer_if;
  import csa_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DEF_IN_W-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [DEF_ACC_W-1:0] out_data;
  logic [DEF_CNT_W-1:0] out_count;
  logic                 out_ovf;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf, busy
  );

endinterface

// File: rtl/csa_3to2_row.sv
// csa_3to2_row: one row of full adders without carry propagation.
//   a, b, c  three W-bit addends
//   sum      bitwise a^b^c
//   carry    bitwise majority shifted left by one (top carry dropped, mod 2^W)
// a + b + c == sum + carry (mod 2^W).
module csa_3to2_row #(
  parameter int W = 28
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: streaming multi-operand accumulator for the GEMV
// dot-product path. Folds one operand per cycle into a carry-save pair (S,C),
// resolves S+C with a single carry-propagate add on the frame's last beat and
// holds the result until downstream accepts it.
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset; discards any partial frame
//   bus  csa_accum_sequencer_if.slave (operand stream in, result out, busy)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ACCUM   | accepting operands, one CSA fold per accepted beat
// RESOLVE | one cycle: S+C and the term count are captured into outputs
// HOLD    | result presented on out_*; waits for out_ready, then clears
module csa_accum_sequencer
  import csa_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  csa_accum_sequencer_if.slave bus
);

  localparam int ACC_W = DEF_ACC_W;
  localparam int CNT_W = DEF_CNT_W;

  state_t           state;
  logic [ACC_W-1:0] s_q;
  logic [ACC_W-1:0] c_q;
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] s_nxt;
  logic [ACC_W-1:0] c_nxt;
  logic [CNT_W-1:0] count;
  logic             accept;

  assign x      = ACC_W'(bus.in_data);
  assign accept = bus.in_valid & bus.in_ready;

  csa_3to2_row #(.W(ACC_W)) u_row (
    .a    (s_q),
    .b    (c_q),
    .c    (x),
    .sum  (s_nxt),
    .carry(c_nxt)
  );

  assign bus.busy = (state != ACCUM) | (|s_q) | (|c_q) | (|count);

  // in_ready is registered: it drops together with the move to RESOLVE so
  // no beat can be accepted while a result is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ACCUM;
      s_q           <= '0;
      c_q           <= '0;
      count         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            s_q <= s_nxt;
            c_q <= c_nxt;
            if (count != '1) count <= count + 1'b1;
            if (bus.in_last) begin
              state        <= RESOLVE;
              bus.in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          bus.out_data  <= s_q + c_q;
          bus.out_count <= count;
          bus.out_ovf   <= (count > CNT_W'(DEF_MAX_TERMS));
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            s_q           <= '0;
            c_q           <= '0;
            count         <= '0;
            bus.in_ready  <= 1'b1;
            state         <= ACCUM;
          end
        end
        default: begin
          state        <= ACCUM;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
module tb_csa_accum_sequencer;
  import csa_pkg::*;

  typedef struct packed {
    logic [DEF_ACC_W-1:0] data;
    logic [DEF_CNT_W-1:0] count;
    logic                 ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  csa_accum_sequencer_if bus ();

  csa_accum_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens on the falling edge.
  task automatic send_beat(input logic [DEF_IN_W-1:0] d, input logic last);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_beat: in_ready never rose (got %b, want 1)", bus.in_ready);
    end
    @(negedge clk);
  endtask

  // Pushes the model's expectation, then streams the frame with 'gap' idle cycles between beats.
  task automatic send_frame(input logic [DEF_IN_W-1:0] ops[$], input int gap);
    exp_t e;
    logic [DEF_ACC_W-1:0] sum = '0;
    int n = ops.size();
    foreach (ops[i]) sum = sum + DEF_ACC_W'(ops[i]);
    e.data  = sum;
    e.count = (n > 255) ? DEF_CNT_W'(255) : DEF_CNT_W'(n);
    e.ovf   = (n > DEF_MAX_TERMS);
    sb.push_back(e);
    foreach (ops[i]) begin
      send_beat(ops[i], (i == n - 1));
      if (gap > 0 && i != n - 1) begin
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic recv_result(input string name);
    exp_t e;
    int   guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s.out_valid: got %b, want 1 (pending %0d)", name, bus.out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.out_data !== e.data) begin
      n_fail++;
      $display("FAIL %s.out_data: got %h, want %h", name, bus.out_data, e.data);
    end
    n_checks++;
    if (bus.out_count !== e.count) begin
      n_fail++;
      $display("FAIL %s.out_count: got %0d, want %0d", name, bus.out_count, e.count);
    end
    n_checks++;
    if (bus.out_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL %s.out_ovf: got %b, want %b", name, bus.out_ovf, e.ovf);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s.out_valid_clear: got %b, want 0", name, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    got = {bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy, |bus.out_data | |bus.out_count};
    n_checks++;
    if (got !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset.{in_ready,out_valid,ovf,busy,data|count}: got %b, want 10000", got);
    end
  endtask

  task automatic test_basic();
    logic [DEF_IN_W-1:0] ops[$];
    ops = '{21'd5, 21'd7, 21'd9};
    send_frame(ops, 0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic.resolve_cycle: out_valid=%b in_ready=%b, want 0 0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic.latency: out_valid=%b at t+2, want 1", bus.out_valid);
    end
    recv_result("basic");
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic.after: in_ready=%b busy=%b, want 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_single();
    logic [DEF_IN_W-1:0] ops[$];
    ops = '{21'h1FFFFF};
    send_frame(ops, 0);
    recv_result("single");
  endtask

  task automatic test_overflow();
    logic [DEF_IN_W-1:0] ops[$];
    ops = {};
    repeat (128) ops.push_back(21'h1FFFFF);
    send_frame(ops, 0);
    recv_result("terms128");
    ops.push_back(21'h1FFFFF);
    send_frame(ops, 0);
    recv_result("terms129");
    ops = {};
    repeat (300) ops.push_back(21'd1);
    send_frame(ops, 0);
    recv_result("saturate300");
  endtask

  task automatic test_backpressure();
    logic [DEF_IN_W-1:0] ops[$];
    int guard = 0;
    ops = '{21'd10, 21'd20};
    send_frame(ops, 0);
    // Next frame's beat is already presented while the result is pending.
    bus.in_valid = 1'b1;
    bus.in_data  = 21'd7;
    bus.in_last  = 1'b1;
    sb.push_back('{data: 28'd7, count: 8'd1, ovf: 1'b0});
    while (bus.out_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== sb[0].data || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: valid=%b data=%h ready=%b, want 1 %h 0",
                 i, bus.out_valid, bus.out_data, bus.in_ready, sb[0].data);
      end
      @(negedge clk);
    end
    recv_result("stall");
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall.ready_after_handshake: got %b, want 1", bus.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall.next_accept: in_ready=%b, want 0 (beat taken)", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    recv_result("stall_next");
  endtask

  task automatic test_gaps();
    logic [DEF_IN_W-1:0] ops[$];
    ops = '{21'd1, 21'd2, 21'd3};
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_frame(ops, 2);
    recv_result("gaps");
  endtask

  task automatic test_reset_mid();
    logic [DEF_IN_W-1:0] ops[$];
    send_beat(21'd100, 1'b0);
    send_beat(21'd200, 1'b0);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid.busy_before: got %b, want 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid.async: busy=%b in_ready=%b, want 0 1", bus.busy, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid.no_output[%0d]: got %b, want 0", i, bus.out_valid);
      end
      @(negedge clk);
    end
    ops = '{21'd4};
    send_frame(ops, 0);
    recv_result("after_rst");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_single();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard.drain: %0d results left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
